// File: rtl/tx_pkg.sv
// Shared transmit-path definitions: loader FSM states, length limits and MAC constants.
package tx_pkg;

    localparam int unsigned LEN_W         = 11;
    localparam int unsigned HDR_BYTES     = 2;
    localparam int unsigned MIN_PAYLOAD_C = 46;
    localparam int unsigned MAX_PAYLOAD_C = 1500;

    localparam logic [47:0] SRC_MAC_C = 48'h02_00_00_00_00_01;
    localparam logic [47:0] DST_MAC_C = 48'hFF_FF_FF_FF_FF_FF;

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StData,
        StPad,
        StDrain,
        StDone
    } loader_state_e;

    // Length that goes on the wire: short payloads are padded up to the minimum.
    function automatic logic [LEN_W-1:0] eff_len_f(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] min_len);
        return (len < min_len) ? min_len : len;
    endfunction

endpackage

// File: rtl/tx_pkt_loader_if.sv
// User-side payload stream into the transmit loader: start/length request plus byte stream.
interface tx_pkt_loader_if;
    import tx_pkg::*;

    logic             s_start;
    logic [LEN_W-1:0] s_len;
    logic             s_start_ready;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;

    modport master (
        output s_start, s_len, s_data, s_valid, s_last,
        input  s_start_ready, s_ready
    );

    modport slave (
        input  s_start, s_len, s_data, s_valid, s_last,
        output s_start_ready, s_ready
    );

endinterface

// File: rtl/pkt_credit_cnt.sv
// Queued-packet credit counter: +1 per queued packet, -1 per transmitted packet, saturating.
module pkt_credit_cnt #(
    parameter int unsigned MaxInflight = 2,
    parameter int unsigned CntW        = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            dec,
    output logic [CntW-1:0] count,
    output logic            avail
);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        // Simultaneous inc/dec cancel; a stray dec at zero is dropped.
        if (inc && !dec && (count_q < CntW'(MaxInflight))) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign avail = (count_q < CntW'(MaxInflight));

endmodule

// File: rtl/tx_pkt_loader.sv
// Frames user payload into the TX FIFO as [len_hi, len_lo, payload, zero pad].
// Optional statistics counters are built when TX_LOADER_STATS_EN is defined.
module tx_pkt_loader
    import tx_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned MIN_PAYLOAD  = MIN_PAYLOAD_C,
    parameter int unsigned MAX_PAYLOAD  = MAX_PAYLOAD_C,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input  logic               clk,
    input  logic               rst,
    tx_pkt_loader_if.slave     up,
    input  logic               pct_txed,
    output logic [WIDTH-1:0]   data_in,
    output logic               buf_w_en,
    output logic               pct_qued,
    output logic               len_err,
    output logic [1:0]         inflight
`ifdef TX_LOADER_STATS_EN
    ,
    output logic [31:0]        stat_pkts,
    output logic [31:0]        stat_bytes,
    output logic [15:0]        stat_errs
`endif
);

    localparam logic [LEN_W-1:0] MinLen = LEN_W'(MIN_PAYLOAD);
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_PAYLOAD);

    loader_state_e    state_q, state_d;
    logic [LEN_W-1:0] eff_len_q, eff_len_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] cnt_inc;
    logic             wr_en_d;
    logic [WIDTH-1:0] wr_data_d;
    logic             start_avail;

    assign cnt_inc = cnt_q + 1'b1;

    pkt_credit_cnt #(
        .MaxInflight(MAX_INFLIGHT),
        .CntW       (2)
    ) u_credit (
        .clk  (clk),
        .rst  (rst),
        .inc  (pct_qued),
        .dec  (pct_txed),
        .count(inflight),
        .avail(start_avail)
    );

    always_comb begin
        state_d          = state_q;
        eff_len_d        = eff_len_q;
        rem_d            = rem_q;
        cnt_d            = cnt_q;
        wr_en_d          = 1'b0;
        wr_data_d        = '0;
        up.s_start_ready = 1'b0;
        up.s_ready       = 1'b0;
        len_err          = 1'b0;
        pct_qued         = 1'b0;

        unique case (state_q)
            StIdle: begin
                up.s_start_ready = start_avail;
                if (up.s_start && start_avail) begin
                    if ((up.s_len == '0) || (up.s_len > MaxLen)) begin
                        len_err = 1'b1;
                    end else begin
                        eff_len_d = eff_len_f(up.s_len, MinLen);
                        rem_d     = up.s_len;
                        cnt_d     = '0;
                        state_d   = StHdrHi;
                    end
                end
            end
            StHdrHi: begin
                wr_en_d   = 1'b1;
                wr_data_d = WIDTH'(eff_len_q >> 8);
                state_d   = StHdrLo;
            end
            StHdrLo: begin
                wr_en_d   = 1'b1;
                wr_data_d = WIDTH'(eff_len_q[7:0]);
                state_d   = StData;
            end
            StData: begin
                up.s_ready = 1'b1;
                if (up.s_valid) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = WIDTH'(up.s_data);
                    rem_d     = rem_q - 1'b1;
                    cnt_d     = cnt_inc;
                    if (rem_q == LEN_W'(1)) begin
                        if (!up.s_last) begin
                            len_err = 1'b1;
                            state_d = StDrain;
                        end else if (cnt_inc < eff_len_q) begin
                            state_d = StPad;
                        end else begin
                            state_d = StDone;
                        end
                    end else if (up.s_last) begin
                        // Early end: still pad to the advertised length.
                        len_err = 1'b1;
                        state_d = StPad;
                    end
                end
            end
            StPad: begin
                wr_en_d   = 1'b1;
                wr_data_d = '0;
                cnt_d     = cnt_inc;
                if (cnt_inc == eff_len_q) begin
                    state_d = StDone;
                end
            end
            StDrain: begin
                up.s_ready = 1'b1;
                // Overlong short packets still need padding so the header stays truthful.
                if (up.s_valid && up.s_last) begin
                    state_d = (cnt_q < eff_len_q) ? StPad : StDone;
                end
            end
            StDone: begin
                pct_qued = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Hold every combinational output low while reset is asserted.
        if (rst) begin
            up.s_start_ready = 1'b0;
            up.s_ready       = 1'b0;
            len_err          = 1'b0;
            pct_qued         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            eff_len_q <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            buf_w_en  <= 1'b0;
            data_in   <= '0;
        end else begin
            state_q   <= state_d;
            eff_len_q <= eff_len_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            buf_w_en  <= wr_en_d;
            data_in   <= wr_data_d;
        end
    end

`ifdef TX_LOADER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts  <= '0;
            stat_bytes <= '0;
            stat_errs  <= '0;
        end else begin
            if (pct_qued) begin
                stat_pkts  <= stat_pkts + 1'b1;
                stat_bytes <= stat_bytes + 32'(eff_len_q);
            end
            if (len_err) begin
                stat_errs <= stat_errs + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tx_pkt_loader.sv
// Self-checking bench for tx_pkt_loader: directed cases plus randomized packets vs a framing model.
`timescale 1ns/1ps
module tb_tx_pkt_loader;
    import tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       pct_txed;
    logic [7:0] data_in;
    logic       buf_w_en;
    logic       pct_qued;
    logic       len_err;
    logic [1:0] inflight;
`ifdef TX_LOADER_STATS_EN
    logic [31:0] stat_pkts;
    logic [31:0] stat_bytes;
    logic [15:0] stat_errs;
`endif

    tx_pkt_loader_if up_if ();

    tx_pkt_loader dut (
        .clk      (clk),
        .rst      (rst),
        .up       (up_if),
        .pct_txed (pct_txed),
        .data_in  (data_in),
        .buf_w_en (buf_w_en),
        .pct_qued (pct_qued),
        .len_err  (len_err),
        .inflight (inflight)
`ifdef TX_LOADER_STATS_EN
        ,
        .stat_pkts (stat_pkts),
        .stat_bytes(stat_bytes),
        .stat_errs (stat_errs)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] wr_q[$];
    int         qued_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] pay[$];
    int         exp_inflight = 0;
    int         pkts_m = 0;
    int         bytes_m = 0;
    int         errs_m = 0;

    // Observe the FIFO side just before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (buf_w_en === 1'b1) wr_q.push_back(data_in);
        if (pct_qued === 1'b1) qued_cnt++;
        if (len_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic txed();
        @(negedge clk);
        pct_txed = 1'b1;
        @(negedge clk);
        pct_txed      = 1'b0;
        up_if.s_start = 1'b0;
        if (exp_inflight > 0) exp_inflight--;
        #1;
        check("inflight after pct_txed", 32'(inflight), 32'(exp_inflight));
    endtask

    // Send one packet of declared length len whose source emits nbeats bytes from pay[].
    task automatic run_pkt(input string tag, input int len, input int nbeats, input bit gaps);
        logic [7:0] exp_q[$];
        int eff, n, q0, e0, cyc;
        eff = (len < int'(MIN_PAYLOAD_C)) ? int'(MIN_PAYLOAD_C) : len;
        exp_q.push_back(8'(eff >> 8));
        exp_q.push_back(8'(eff));
        n = (nbeats < len) ? nbeats : len;
        for (int i = 0; i < n; i++) exp_q.push_back(pay[i]);
        while (exp_q.size() < eff + int'(HDR_BYTES)) exp_q.push_back(8'h00);

        wr_q.delete();
        q0 = qued_cnt;
        e0 = err_cnt;
        @(negedge clk);
        up_if.s_start = 1'b1;
        up_if.s_len   = 11'(len);
        cyc = 0;
        #1;
        while (up_if.s_start_ready !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check({tag, " start accepted"}, 32'(cyc < 200), 32'd1);
        @(negedge clk);
        up_if.s_start = 1'b0;

        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                while ($urandom_range(3) == 0) begin
                    up_if.s_valid = 1'b0;
                    @(negedge clk);
                end
            end
            up_if.s_valid = 1'b1;
            up_if.s_data  = pay[i];
            up_if.s_last  = (i == nbeats - 1);
            cyc = 0;
            #1;
            while (up_if.s_ready !== 1'b1 && cyc < 200) begin
                @(negedge clk);
                #1;
                cyc++;
            end
            if (cyc >= 200) begin
                check({tag, " beat accepted"}, 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
        end
        up_if.s_valid = 1'b0;
        up_if.s_last  = 1'b0;

        cyc = 0;
        while (qued_cnt == q0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check({tag, " pct_qued pulses"}, 32'(qued_cnt - q0), 32'd1);
        check({tag, " write count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check($sformatf("%s byte %0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
        end
        check({tag, " len_err pulses"}, 32'(err_cnt - e0), 32'(nbeats != len));
        if (exp_inflight < 2) exp_inflight++;
        check({tag, " inflight"}, 32'(inflight), 32'(exp_inflight));
        pkts_m++;
        bytes_m += eff;
        if (nbeats != len) errs_m++;
    endtask

    initial begin
        int q0, e0, len, nb, mode, got;
        int bad_lens[3];
        rst           = 1'b1;
        pct_txed      = 1'b0;
        up_if.s_start = 1'b0;
        up_if.s_len   = '0;
        up_if.s_data  = '0;
        up_if.s_valid = 1'b0;
        up_if.s_last  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst buf_w_en", 32'(buf_w_en), 32'd0);
        check("rst data_in", 32'(data_in), 32'd0);
        check("rst pct_qued", 32'(pct_qued), 32'd0);
        check("rst len_err", 32'(len_err), 32'd0);
        check("rst inflight", 32'(inflight), 32'd0);
        check("rst s_start_ready", 32'(up_if.s_start_ready), 32'd0);
        check("rst s_ready", 32'(up_if.s_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle s_start_ready", 32'(up_if.s_start_ready), 32'd1);

        // 60-byte packet 0x01..0x3C
        pay.delete();
        for (int i = 0; i < 60; i++) pay.push_back(8'(i + 1));
        run_pkt("len60", 60, 60, 1'b0);
        txed();

        // Short packet padded to minimum
        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back(8'($urandom));
        run_pkt("len10", 10, 10, 1'b1);
        txed();

        // Credit limit: two queued, third held until pct_txed
        pay.delete();
        for (int i = 0; i < 64; i++) pay.push_back(8'($urandom));
        run_pkt("b2b pkt1", 64, 64, 1'b0);
        run_pkt("b2b pkt2", 64, 64, 1'b0);
        wr_q.delete();
        @(negedge clk);
        up_if.s_start = 1'b1;
        up_if.s_len   = 11'd64;
        repeat (4) begin
            #1;
            check("held s_start_ready", 32'(up_if.s_start_ready), 32'd0);
            @(negedge clk);
        end
        check("held no writes", 32'(wr_q.size()), 32'd0);
        txed();
        check("released s_start_ready", 32'(up_if.s_start_ready), 32'd1);
        run_pkt("b2b pkt3", 64, 64, 1'b0);
        txed();
        txed();
        txed();

        // Early s_last: pad to declared length
        pay.delete();
        for (int i = 0; i < 50; i++) pay.push_back(8'($urandom));
        run_pkt("early last", 50, 40, 1'b0);
        txed();

        // Illegal lengths rejected in the request cycle
        bad_lens[0] = 1501;
        bad_lens[1] = 0;
        bad_lens[2] = 2047;
        foreach (bad_lens[k]) begin
            wr_q.delete();
            e0 = err_cnt;
            @(negedge clk);
            up_if.s_start = 1'b1;
            up_if.s_len   = 11'(bad_lens[k]);
            #1;
            check($sformatf("bad len %0d len_err", bad_lens[k]), 32'(len_err), 32'd1);
            @(negedge clk);
            up_if.s_start = 1'b0;
            repeat (4) @(negedge clk);
            check($sformatf("bad len %0d no writes", bad_lens[k]), 32'(wr_q.size()), 32'd0);
            check($sformatf("bad len %0d err count", bad_lens[k]), 32'(err_cnt - e0), 32'd1);
            #1;
            check($sformatf("bad len %0d idle", bad_lens[k]), 32'(up_if.s_start_ready), 32'd1);
            errs_m++;
        end

        // Maximum length
        pay.delete();
        for (int i = 0; i < 1500; i++) pay.push_back(8'($urandom));
        run_pkt("len1500", 1500, 1500, 1'b0);

        // Reset in the middle of DATA
        pay.delete();
        for (int i = 0; i < 60; i++) pay.push_back(8'($urandom));
        q0 = qued_cnt;
        @(negedge clk);
        up_if.s_start = 1'b1;
        up_if.s_len   = 11'd60;
        #1;
        check("midrst start ready", 32'(up_if.s_start_ready), 32'd1);
        @(negedge clk);
        up_if.s_start = 1'b0;
        got = 0;
        for (int c = 0; c < 100 && got < 20; c++) begin
            up_if.s_valid = 1'b1;
            up_if.s_data  = pay[got];
            #1;
            if (up_if.s_ready === 1'b1) got++;
            @(negedge clk);
        end
        check("midrst beats sent", 32'(got), 32'd20);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst buf_w_en", 32'(buf_w_en), 32'd0);
        check("midrst data_in", 32'(data_in), 32'd0);
        check("midrst pct_qued", 32'(pct_qued), 32'd0);
        check("midrst len_err", 32'(len_err), 32'd0);
        check("midrst inflight", 32'(inflight), 32'd0);
        check("midrst s_ready", 32'(up_if.s_ready), 32'd0);
        up_if.s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_inflight = 0;
        pkts_m = 0;
        bytes_m = 0;
        errs_m = 0;
        check("midrst no pct_qued", 32'(qued_cnt - q0), 32'd0);
        pay.delete();
        for (int i = 0; i < 30; i++) pay.push_back(8'($urandom));
        run_pkt("after rst", 30, 30, 1'b1);
        txed();

        // Randomized packets
        for (int p = 0; p < 10; p++) begin
            len  = $urandom_range(120, 1);
            mode = $urandom_range(3);
            if (mode == 2) nb = $urandom_range(len, 1);
            else if (mode == 3) nb = len + $urandom_range(5, 1);
            else nb = len;
            pay.delete();
            for (int i = 0; i < nb; i++) pay.push_back(8'($urandom));
            run_pkt($sformatf("rand%0d", p), len, nb, 1'b1);
            txed();
        end

`ifdef TX_LOADER_STATS_EN
        check("stat_pkts", stat_pkts, 32'(pkts_m));
        check("stat_bytes", stat_bytes, 32'(bytes_m));
        check("stat_errs", 32'(stat_errs), 32'(errs_m));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
